// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: keeps fetch-stage predictions in an in-order FIFO, checks the
// oldest one against the outcome from execute, and issues predictor/BTB updates plus a
// redirect on mispredict. Optional statistics counters are built when BRU_STATS_EN is defined.
//
// Ports:
//   clk, rst                          single clock, synchronous active-high reset
//   pred_valid/pred_ready/pred_*      fetch-side push of {pc, hit, taken, target}
//   res_valid/res_cond/res_taken/res_target   execute-side resolution of the oldest record
//   flush                             external squash, clears all records
//   update_predictor, update_btb      one-cycle training pulses (registered)
//   actually_taken, resolved_pc, resolved_pc_target   resolved data (held between pulses)
//   redirect_valid, redirect_pc       one-cycle mispredict redirect (registered)
//   empty, underflow_err              FIFO status and sticky resolve-on-empty error
//   stat_resolved, stat_mispred       saturating counters (only with BRU_STATS_EN)
//
// Latency: a resolve in cycle N produces outputs in cycle N+1. A push in cycle N is
// resolvable in cycle N+1. pred_ready/empty come only from registered pointers.
module branch_resolve_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid,
  output logic                  pred_ready,
  input  logic [DATA_WIDTH-1:0] pred_pc,
  input  logic                  pred_hit,
  input  logic                  pred_taken,
  input  logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  res_valid,
  input  logic                  res_cond,
  input  logic                  res_taken,
  input  logic [DATA_WIDTH-1:0] res_target,
  input  logic                  flush,
  output logic                  update_predictor,
  output logic                  update_btb,
  output logic                  actually_taken,
  output logic [DATA_WIDTH-1:0] resolved_pc,
  output logic [DATA_WIDTH-1:0] resolved_pc_target,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  empty,
`ifdef BRU_STATS_EN
  output logic [31:0]           stat_resolved,
  output logic [31:0]           stat_mispred,
`endif
  output logic                  underflow_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic                  hit;
    logic                  taken;
    logic [DATA_WIDTH-1:0] target;
  } rec_t;

  rec_t mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;

  logic                  full;
  rec_t                  head;
  logic                  resolve_fire;
  logic                  mispredict;
  logic                  wipe;
  logic                  push_fire;
  logic [DATA_WIDTH-1:0] predicted_next;
  logic [DATA_WIDTH-1:0] actual_next;

  logic                  upd_pred_q;
  logic                  upd_btb_q;
  logic                  act_taken_q;
  logic [DATA_WIDTH-1:0] res_pc_q;
  logic [DATA_WIDTH-1:0] res_tgt_q;
  logic                  redir_vld_q;
  logic [DATA_WIDTH-1:0] redir_pc_q;
  logic                  uflow_q;

  assign empty      = (wptr_q == rptr_q);
  assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pred_ready = !full;
  assign head       = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    resolve_fire   = res_valid && !empty;
    predicted_next = (head.hit && head.taken) ? head.target : head.pc + PC_STEP;
    actual_next    = res_taken ? res_target : head.pc + PC_STEP;
    mispredict     = resolve_fire && (predicted_next != actual_next);
    // Anything fetched alongside a mispredict or flush is on the wrong path.
    wipe           = flush || mispredict;
    push_fire      = pred_valid && !full && !wipe;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wipe) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_fire)    wptr_d = wptr_q + PTR_ONE;
      if (resolve_fire) rptr_d = rptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read between valid pointers.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wptr_q[AW-1:0]] <= '{pc: pred_pc, hit: pred_hit, taken: pred_taken,
                                 target: pred_target};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      upd_pred_q  <= 1'b0;
      upd_btb_q   <= 1'b0;
      act_taken_q <= 1'b0;
      res_pc_q    <= '0;
      res_tgt_q   <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      uflow_q     <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      upd_pred_q  <= resolve_fire && res_cond;
      upd_btb_q   <= resolve_fire && res_taken;
      // A flush squashes the redirect but the resolved instruction still trains.
      redir_vld_q <= mispredict && !flush;
      if (resolve_fire) begin
        act_taken_q <= res_taken;
        res_pc_q    <= head.pc;
        res_tgt_q   <= res_target;
      end
      if (mispredict && !flush) begin
        redir_pc_q <= actual_next;
      end
      if (res_valid && empty) begin
        uflow_q <= 1'b1;
      end
    end
  end

  assign update_predictor   = upd_pred_q;
  assign update_btb         = upd_btb_q;
  assign actually_taken     = act_taken_q;
  assign resolved_pc        = res_pc_q;
  assign resolved_pc_target = res_tgt_q;
  assign redirect_valid     = redir_vld_q;
  assign redirect_pc        = redir_pc_q;
  assign underflow_err      = uflow_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_res_q;
  logic [31:0] stat_mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (resolve_fire && (stat_res_q != '1)) begin
        stat_res_q <= stat_res_q + 32'd1;
      end
      if (mispredict && !flush && (stat_mis_q != '1)) begin
        stat_mis_q <= stat_mis_q + 32'd1;
      end
    end
  end

  assign stat_resolved = stat_res_q;
  assign stat_mispred  = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a randomized run
// compared against a queue-based reference model of the prediction records.
module tb_branch_resolve_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pred_valid, pred_hit, pred_taken;
  logic [DW-1:0] pred_pc, pred_target;
  logic          res_valid, res_cond, res_taken;
  logic [DW-1:0] res_target;
  logic          flush;
  logic          pred_ready, update_predictor, update_btb, actually_taken;
  logic [DW-1:0] resolved_pc, resolved_pc_target, redirect_pc;
  logic          redirect_valid, empty, underflow_err;
`ifdef BRU_STATS_EN
  logic [31:0]   stat_resolved, stat_mispred;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_cond(res_cond), .res_taken(res_taken),
    .res_target(res_target), .flush(flush),
    .update_predictor(update_predictor), .update_btb(update_btb),
    .actually_taken(actually_taken), .resolved_pc(resolved_pc),
    .resolved_pc_target(resolved_pc_target), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .empty(empty),
`ifdef BRU_STATS_EN
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
    .underflow_err(underflow_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } rec_t;

  rec_t        mq[$];
  logic        e_upd_pred, e_upd_btb, e_act, e_redir, e_uflow;
  logic [31:0] e_rpc, e_rtgt, e_redir_pc, e_sres, e_smis;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic idle();
    pred_valid = 0; pred_hit = 0; pred_taken = 0; pred_pc = '0; pred_target = '0;
    res_valid = 0; res_cond = 0; res_taken = 0; res_target = '0; flush = 0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic hit, input logic tk,
                          input logic [31:0] tgt);
    pred_valid = 1; pred_pc = pc; pred_hit = hit; pred_taken = tk; pred_target = tgt;
  endtask

  task automatic set_res(input logic cond, input logic tk, input logic [31:0] tgt);
    res_valid = 1; res_cond = cond; res_taken = tk; res_target = tgt;
  endtask

  // Reference model: advance one clock from the currently driven inputs.
  task automatic tick();
    rec_t h, r;
    logic [31:0] pn, an;
    logic res_ok, mis, push_ok;
    push_ok = pred_valid && (mq.size() < DEPTH);
    if (rst) begin
      mq.delete();
      e_upd_pred = 0; e_upd_btb = 0; e_act = 0; e_redir = 0; e_uflow = 0;
      e_rpc = 0; e_rtgt = 0; e_redir_pc = 0; e_sres = 0; e_smis = 0;
    end else begin
      e_upd_pred = 0; e_upd_btb = 0; e_redir = 0; mis = 0;
      res_ok = res_valid && (mq.size() > 0);
      if (res_valid && mq.size() == 0) e_uflow = 1;
      if (res_ok) begin
        h  = mq[0];
        pn = (h.hit && h.taken) ? h.tgt : h.pc + 32'd4;
        an = res_taken ? res_target : h.pc + 32'd4;
        mis = (pn != an);
        e_upd_pred = res_cond; e_upd_btb = res_taken; e_act = res_taken;
        e_rpc = h.pc; e_rtgt = res_target;
        if (e_sres != 32'hFFFF_FFFF) e_sres = e_sres + 1;
        if (mis && !flush) begin
          e_redir = 1; e_redir_pc = an;
          if (e_smis != 32'hFFFF_FFFF) e_smis = e_smis + 1;
        end
      end
      if (flush || mis) mq.delete();
      else begin
        if (res_ok) void'(mq.pop_front());
        if (push_ok) begin
          r.pc = pred_pc; r.hit = pred_hit; r.taken = pred_taken; r.tgt = pred_target;
          mq.push_back(r);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pred_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", pred_ready); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else n_pass++;
    n_checks++; if ({update_predictor, update_btb, actually_taken, redirect_valid, underflow_err} !== 5'b0)
      $display("FAIL rst_flags: got %b want 00000", {update_predictor, update_btb, actually_taken, redirect_valid, underflow_err});
    else n_pass++;
    n_checks++; if ({resolved_pc, resolved_pc_target, redirect_pc} !== 96'b0)
      $display("FAIL rst_data: got %h %h %h want 0", resolved_pc, resolved_pc_target, redirect_pc); else n_pass++;
  endtask

  task automatic test_correct_taken();
    do_reset();
    set_push(32'h100, 1, 1, 32'h200); tick(); idle();
    set_res(1, 1, 32'h200); tick(); idle();
    n_checks++; if (update_predictor !== 1'b1) $display("FAIL ct_upd_pred: got %b want 1", update_predictor); else n_pass++;
    n_checks++; if (update_btb !== 1'b1) $display("FAIL ct_upd_btb: got %b want 1", update_btb); else n_pass++;
    n_checks++; if (resolved_pc !== 32'h100) $display("FAIL ct_rpc: got %h want 100", resolved_pc); else n_pass++;
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL ct_redir: got %b want 0", redirect_valid); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL ct_empty: got %b want 1", empty); else n_pass++;
    tick();
    n_checks++; if (update_predictor !== 1'b0) $display("FAIL ct_pulse_len: got %b want 0", update_predictor); else n_pass++;
    n_checks++; if (resolved_pc !== 32'h100) $display("FAIL ct_hold: got %h want 100", resolved_pc); else n_pass++;
  endtask

  task automatic test_mispredict_nohit();
    do_reset();
    set_push(32'h100, 0, 0, 32'h0); tick(); idle();
    set_res(1, 1, 32'h180); tick(); idle();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL mn_redir: got %b want 1", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h180) $display("FAIL mn_redir_pc: got %h want 180", redirect_pc); else n_pass++;
    n_checks++; if (update_btb !== 1'b1) $display("FAIL mn_upd_btb: got %b want 1", update_btb); else n_pass++;
    n_checks++; if (resolved_pc_target !== 32'h180) $display("FAIL mn_rtgt: got %h want 180", resolved_pc_target); else n_pass++;
  endtask

  task automatic test_wrong_path();
    do_reset();
    set_push(32'h100, 1, 1, 32'h200); tick();
    set_push(32'h200, 0, 0, 32'h0);   tick();
    set_push(32'h204, 0, 0, 32'h0);   tick(); idle();
    set_res(1, 0, 32'h0); tick(); idle();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL wp_redir: got %b want 1", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h104) $display("FAIL wp_redir_pc: got %h want 104", redirect_pc); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL wp_empty: got %b want 1", empty); else n_pass++;
    n_checks++; if (update_btb !== 1'b0) $display("FAIL wp_upd_btb: got %b want 0", update_btb); else n_pass++;
    set_res(1, 1, 32'h0); tick(); idle();
    n_checks++; if (underflow_err !== 1'b1) $display("FAIL wp_uflow: got %b want 1", underflow_err); else n_pass++;
    n_checks++; if ({update_predictor, redirect_valid} !== 2'b00)
      $display("FAIL wp_uflow_pulse: got %b want 00", {update_predictor, redirect_valid}); else n_pass++;
    tick();
    n_checks++; if (underflow_err !== 1'b1) $display("FAIL wp_uflow_sticky: got %b want 1", underflow_err); else n_pass++;
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_push(32'h1000 + 32'(i * 8), 0, 0, 32'h0); tick();
    end
    idle();
    n_checks++; if (pred_ready !== 1'b0) $display("FAIL fw_full: got %b want 0", pred_ready); else n_pass++;
    set_push(32'hDEAD_0000, 0, 0, 32'h0); tick(); idle();   // refused while full
    set_res(1, 0, 32'h0); tick(); idle();
    n_checks++; if (resolved_pc !== 32'h1000) $display("FAIL fw_first: got %h want 1000", resolved_pc); else n_pass++;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      set_push(32'h2000 + 32'(i * 8), 0, 0, 32'h0);
      set_res(1, 0, 32'h0);
      tick();
      exp_pc = (i < DEPTH - 1) ? 32'h1008 + 32'(i * 8) : 32'h2000 + 32'((i - (DEPTH - 1)) * 8);
      n_checks++; if (resolved_pc !== exp_pc) $display("FAIL fw_order[%0d]: got %h want %h", i, resolved_pc, exp_pc); else n_pass++;
      n_checks++; if (redirect_valid !== 1'b0) $display("FAIL fw_redir[%0d]: got %b want 0", i, redirect_valid); else n_pass++;
      n_checks++; if (pred_ready !== 1'b1) $display("FAIL fw_ready[%0d]: got %b want 1", i, pred_ready); else n_pass++;
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    set_push(32'h300, 1, 1, 32'h340); tick(); idle();
    set_res(0, 1, 32'h340); flush = 1; set_push(32'h340, 0, 0, 32'h0); tick(); idle();
    n_checks++; if (update_btb !== 1'b1) $display("FAIL fl_upd_btb: got %b want 1", update_btb); else n_pass++;
    n_checks++; if (update_predictor !== 1'b0) $display("FAIL fl_upd_pred: got %b want 0", update_predictor); else n_pass++;
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL fl_redir: got %b want 0", redirect_valid); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL fl_empty: got %b want 1", empty); else n_pass++;
    set_push(32'h400, 0, 0, 32'h0); tick(); tick(); idle();
    flush = 1; set_res(1, 1, 32'h900); tick(); idle();      // flush beats a mispredict
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL fl_mis_redir: got %b want 0", redirect_valid); else n_pass++;
    n_checks++; if (update_predictor !== 1'b1) $display("FAIL fl_mis_upd: got %b want 1", update_predictor); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL fl_mis_empty: got %b want 1", empty); else n_pass++;
    set_push(32'h500, 0, 0, 32'h0); tick(); idle();
    flush = 1; tick(); idle();
    n_checks++; if ({empty, update_predictor, update_btb} !== 3'b100)
      $display("FAIL fl_alone: got %b want 100", {empty, update_predictor, update_btb}); else n_pass++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    set_push(32'h600, 0, 0, 32'h0); tick();
    set_push(32'h604, 0, 0, 32'h0); set_res(1, 1, 32'h700); tick(); idle();
    set_push(32'h608, 0, 0, 32'h0); set_res(1, 1, 32'h800); rst = 1; tick(); rst = 0; idle();
    n_checks++; if ({update_predictor, update_btb, actually_taken, redirect_valid} !== 4'b0)
      $display("FAIL rm_flags: got %b want 0000", {update_predictor, update_btb, actually_taken, redirect_valid}); else n_pass++;
    n_checks++; if ({resolved_pc, resolved_pc_target, redirect_pc} !== 96'b0)
      $display("FAIL rm_data: got %h %h %h want 0", resolved_pc, resolved_pc_target, redirect_pc); else n_pass++;
    n_checks++; if ({empty, pred_ready} !== 2'b11) $display("FAIL rm_status: got %b want 11", {empty, pred_ready}); else n_pass++;
  endtask

`ifdef BRU_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_push(32'hA00 + 32'(i * 16), 0, 0, 32'h0); tick(); idle();
      set_res(1, (i == 1 || i == 3), 32'h500); tick(); idle();
    end
    n_checks++; if (stat_resolved !== 32'd5) $display("FAIL st_res: got %0d want 5", stat_resolved); else n_pass++;
    n_checks++; if (stat_mispred !== 32'd2) $display("FAIL st_mis: got %0d want 2", stat_mispred); else n_pass++;
  endtask
`endif

  task automatic test_random();
    rec_t h;
    logic [31:0] pc;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      rst = ($urandom_range(99) < 1);
      if ($urandom_range(1)) begin
        pc = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
        set_push(pc, 1'($urandom), 1'($urandom), $urandom & 32'h0000_FFFC);
      end
      if ($urandom_range(99) < 55) begin
        res_valid = 1;
        res_cond  = 1'($urandom);
        res_target = $urandom & 32'h0000_FFFC;
        res_taken = res_cond ? 1'($urandom) : 1'b1;
        // Bias toward correct predictions so the FIFO fills and drains.
        if (mq.size() > 0 && $urandom_range(99) < 65) begin
          h = mq[0];
          if (h.hit && h.taken) begin res_taken = 1; res_target = h.tgt; end
          else if (res_cond) res_taken = 0;
          else res_target = h.pc + 32'd4;
        end
      end
      flush = ($urandom_range(99) < 4);
      tick();
      rst = 0;
      n_checks++; if (pred_ready !== (mq.size() < DEPTH)) $display("FAIL rnd_ready[%0d]: got %b want %b", c, pred_ready, mq.size() < DEPTH); else n_pass++;
      n_checks++; if (empty !== (mq.size() == 0)) $display("FAIL rnd_empty[%0d]: got %b want %b", c, empty, mq.size() == 0); else n_pass++;
      n_checks++; if (update_predictor !== e_upd_pred) $display("FAIL rnd_upd_pred[%0d]: got %b want %b", c, update_predictor, e_upd_pred); else n_pass++;
      n_checks++; if (update_btb !== e_upd_btb) $display("FAIL rnd_upd_btb[%0d]: got %b want %b", c, update_btb, e_upd_btb); else n_pass++;
      n_checks++; if (actually_taken !== e_act) $display("FAIL rnd_act[%0d]: got %b want %b", c, actually_taken, e_act); else n_pass++;
      n_checks++; if (resolved_pc !== e_rpc) $display("FAIL rnd_rpc[%0d]: got %h want %h", c, resolved_pc, e_rpc); else n_pass++;
      n_checks++; if (resolved_pc_target !== e_rtgt) $display("FAIL rnd_rtgt[%0d]: got %h want %h", c, resolved_pc_target, e_rtgt); else n_pass++;
      n_checks++; if (redirect_valid !== e_redir) $display("FAIL rnd_redir[%0d]: got %b want %b", c, redirect_valid, e_redir); else n_pass++;
      n_checks++; if (redirect_pc !== e_redir_pc) $display("FAIL rnd_redir_pc[%0d]: got %h want %h", c, redirect_pc, e_redir_pc); else n_pass++;
      n_checks++; if (underflow_err !== e_uflow) $display("FAIL rnd_uflow[%0d]: got %b want %b", c, underflow_err, e_uflow); else n_pass++;
`ifdef BRU_STATS_EN
      n_checks++; if (stat_resolved !== e_sres) $display("FAIL rnd_sres[%0d]: got %0d want %0d", c, stat_resolved, e_sres); else n_pass++;
      n_checks++; if (stat_mispred !== e_smis) $display("FAIL rnd_smis[%0d]: got %0d want %0d", c, stat_mispred, e_smis); else n_pass++;
`endif
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_correct_taken();
    test_mispredict_nohit();
    test_wrong_path();
    test_full_wrap();
    test_flush();
    test_rst_mid();
`ifdef BRU_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
